// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - shared background tile geometry, attribute layout and colours
// Purpose: constants and the attribute-word type shared by the renderer and the
//          game engine that packs tile attribute words.
// Ports:   none (package)
package bg_pkg;

    localparam int TILE_W    = 16;
    localparam int TILE_H    = 16;
    localparam int TILE_COLS = 40;
    localparam int TILE_ROWS = 30;
    localparam int ACTIVE_V  = TILE_ROWS * TILE_H;
    localparam int LAT       = 4;

    // Attribute word bit positions
    localparam int ATTR_EN     = 8;
    localparam int ATTR_YF     = 7;
    localparam int ATTR_XF     = 6;
    localparam int ATTR_ROW_HI = 5;
    localparam int ATTR_ROW_LO = 3;
    localparam int ATTR_COL_HI = 2;
    localparam int ATTR_COL_LO = 0;

    localparam logic [11:0] TRANSP_COLOR = 12'hF0F;
    localparam logic [11:0] BG_COLOR     = 12'h6AF;

    typedef struct packed {
        logic       en;
        logic       yflip;
        logic       xflip;
        logic [2:0] srow;
        logic [2:0] scol;
    } tile_attr_t;

    function automatic tile_attr_t unpack_attr(input logic [ATTR_EN:0] w);
        tile_attr_t a;
        a.en    = w[ATTR_EN];
        a.yflip = w[ATTR_YF];
        a.xflip = w[ATTR_XF];
        a.srow  = w[ATTR_ROW_HI:ATTR_ROW_LO];
        a.scol  = w[ATTR_COL_HI:ATTR_COL_LO];
        return a;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - pix_tick-enabled shift register for sync/blank flags
// Purpose: delays a W-bit vector by N enabled cycles (N >= 2).
// Ports:   clk, reset (sync, active-high), en_i (advance), d_i (W) in, q_o (W) out
module sync_delay #(
    parameter int W = 3,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [N-1:0][W-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= {sr_q[N-2:0], d_i};
        end
    end

    assign q_o = sr_q[N-1];

endmodule

// File: rtl/bg_tile_renderer.sv
// rtl/bg_tile_renderer.sv - scrolled background tile renderer, 4-tick pixel pipeline
// Purpose: per pixel, applies fine horizontal scroll, reads the tile attribute,
//          fetches the (optionally flipped) texel from the 128x128 pattern sheet
//          and emits RGB plus delayed syncs aligned with it.
// Ports:   clk, reset (sync, active-high), pix_tick (pipeline enable),
//          video_on/hsync_in/vsync_in/x/y (pixel in), bg_x_offset (fine scroll),
//          tile_addr/tile_data (tile RAM, 1-clk latency),
//          pat_addr/pat_data (pattern ROM, 1-clk latency),
//          rgb/bg_opaque (pixel out), hsync_out/vsync_out/video_on_out (delayed).
// Config:  BG_DEBUG_GRID_EN - overlays a white 16x16 grid following the scroll.
// Memory reads are answered on the clock after the address register changes and
// captured on the next pix_tick, so pix_tick must be idle at least one clock in two.
module bg_tile_renderer
    import bg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [3:0]  bg_x_offset,
    output logic [15:0] tile_addr,
    input  logic [31:0] tile_data,
    output logic [13:0] pat_addr,
    input  logic [11:0] pat_data,
    output logic [11:0] rgb,
    output logic        bg_opaque,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        video_on_out
);

    logic [3:0]  off_l_q;
    logic [3:0]  off_eff;
    logic [10:0] xs;
    logic [6:0]  col_raw, col;
    logic [4:0]  row;
    logic [15:0] tile_addr_d, tile_addr_q;
    logic [3:0]  px0_q, py0_q, px1_q, py1_q;
    logic        vid0_q, vid1_q, vid2_q, en2_q;
    tile_attr_t  attr1_q;
    logic [3:0]  pxf, pyf;
    logic [13:0] pat_addr_d, pat_addr_q;
    logic [11:0] rgb_d, rgb_q;
    logic        opaque_d, opaque_q;
`ifdef BG_DEBUG_GRID_EN
    logic        grid2_q;
`endif

    logic unused_tile_bits;
    assign unused_tile_bits = &{1'b0, tile_data[31:ATTR_EN+1]};

    // The x==0 pixel itself already uses the offset being latched for its line.
    always_comb begin
        off_eff     = (x == 10'd0) ? bg_x_offset : off_l_q;
        xs          = {1'b0, x} + {7'd0, off_eff};
        col_raw     = 7'(xs >> $clog2(TILE_W));
        col         = (col_raw >= 7'(TILE_COLS)) ? col_raw - 7'(TILE_COLS) : col_raw;
        row         = (y >= 10'(ACTIVE_V)) ? 5'(TILE_ROWS - 1) : 5'(y >> $clog2(TILE_H));
        tile_addr_d = 16'(col) + 16'(row) * 16'(TILE_COLS);
    end

    always_comb begin
        pxf        = attr1_q.xflip ? ~px1_q : px1_q;
        pyf        = attr1_q.yflip ? ~py1_q : py1_q;
        pat_addr_d = {attr1_q.srow, pyf, attr1_q.scol, pxf};
    end

    always_comb begin
        rgb_d    = '0;
        opaque_d = 1'b0;
        if (!vid2_q) begin
            rgb_d    = '0;
            opaque_d = 1'b0;
        end
`ifdef BG_DEBUG_GRID_EN
        else if (grid2_q) begin
            rgb_d    = 12'hFFF;
            opaque_d = 1'b1;
        end
`endif
        else if (!en2_q || pat_data == TRANSP_COLOR) begin
            rgb_d    = BG_COLOR;
            opaque_d = 1'b0;
        end else begin
            rgb_d    = pat_data;
            opaque_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            off_l_q     <= '0;
            tile_addr_q <= '0;
            px0_q       <= '0;
            py0_q       <= '0;
            vid0_q      <= 1'b0;
            attr1_q     <= '0;
            px1_q       <= '0;
            py1_q       <= '0;
            vid1_q      <= 1'b0;
            pat_addr_q  <= '0;
            en2_q       <= 1'b0;
            vid2_q      <= 1'b0;
            rgb_q       <= '0;
            opaque_q    <= 1'b0;
`ifdef BG_DEBUG_GRID_EN
            grid2_q     <= 1'b0;
`endif
        end else if (pix_tick) begin
            if (x == 10'd0) begin
                off_l_q <= bg_x_offset;
            end
            tile_addr_q <= tile_addr_d;
            px0_q       <= xs[3:0];
            py0_q       <= y[3:0];
            vid0_q      <= video_on;
            attr1_q     <= unpack_attr(tile_data[ATTR_EN:0]);
            px1_q       <= px0_q;
            py1_q       <= py0_q;
            vid1_q      <= vid0_q;
            pat_addr_q  <= pat_addr_d;
            en2_q       <= attr1_q.en;
            vid2_q      <= vid1_q;
            rgb_q       <= rgb_d;
            opaque_q    <= opaque_d;
`ifdef BG_DEBUG_GRID_EN
            grid2_q     <= (pxf == 4'd0) || (pyf == 4'd0);
`endif
        end
    end

    assign tile_addr = tile_addr_q;
    assign pat_addr  = pat_addr_q;
    assign rgb       = rgb_q;
    assign bg_opaque = opaque_q;

    sync_delay #(.W(3), .N(LAT)) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en_i  (pix_tick),
        .d_i   ({hsync_in, vsync_in, video_on}),
        .q_o   ({hsync_out, vsync_out, video_on_out})
    );

endmodule

// File: tb/tb_bg_tile_renderer.sv
// tb/tb_bg_tile_renderer.sv - directed self-checking bench for bg_tile_renderer
module tb_bg_tile_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_tick;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  bg_x_offset;
    logic [15:0] tile_addr;
    logic [31:0] tile_data;
    logic [13:0] pat_addr;
    logic [11:0] pat_data;
    logic [11:0] rgb;
    logic        bg_opaque;
    logic        hsync_out;
    logic        vsync_out;
    logic        video_on_out;

    logic [31:0] tile_mem [0:2047];
    logic [11:0] pat_mem  [0:16383];

    logic [15:0] ta_log  [0:255];
    logic [13:0] pa_log  [0:255];
    logic [11:0] rgb_log [0:255];
    logic        op_log  [0:255];
    logic        vo_log  [0:255];
    logic        hs_log  [0:255];
    logic        vs_log  [0:255];

    int n_chk  = 0;
    int n_pass = 0;
    int tk     = 0;
    int n;

`ifdef BG_DEBUG_GRID_EN
    localparam logic [11:0] EXP_T2 = 12'hFFF;
`else
    localparam logic [11:0] EXP_T2 = 12'h123;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tile_data <= tile_mem[tile_addr[10:0]];
        pat_data  <= pat_mem[pat_addr];
    end

    bg_tile_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .pix_tick     (pix_tick),
        .video_on     (video_on),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .x            (x),
        .y            (y),
        .bg_x_offset  (bg_x_offset),
        .tile_addr    (tile_addr),
        .tile_data    (tile_data),
        .pat_addr     (pat_addr),
        .pat_data     (pat_data),
        .rgb          (rgb),
        .bg_opaque    (bg_opaque),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .video_on_out (video_on_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One pixel tick followed by an idle clock so the memories can answer.
    task automatic step(input int px, input int py, input logic vid, input logic hs, input logic vs);
        x        = 10'(px);
        y        = 10'(py);
        video_on = vid;
        hsync_in = hs;
        vsync_in = vs;
        pix_tick = 1'b1;
        @(posedge clk);
        #1;
        pix_tick    = 1'b0;
        ta_log[tk]  = tile_addr;
        pa_log[tk]  = pat_addr;
        rgb_log[tk] = rgb;
        op_log[tk]  = bg_opaque;
        vo_log[tk]  = video_on_out;
        hs_log[tk]  = hsync_out;
        vs_log[tk]  = vsync_out;
        tk++;
        @(posedge clk);
        #1;
    endtask

    task automatic flush3();
        for (int i = 0; i < 3; i++) step(700, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rgb"}, 32'(rgb), 32'h0);
        chk({tag, "_opq"}, 32'(bg_opaque), 32'h0);
        chk({tag, "_ta"}, 32'(tile_addr), 32'h0);
        chk({tag, "_pa"}, 32'(pat_addr), 32'h0);
        chk({tag, "_syn"}, 32'({hsync_out, vsync_out, video_on_out}), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) tile_mem[i] = 32'h0;
        for (int i = 0; i < 16384; i++) pat_mem[i] = 12'h0A0;
        tile_mem[0]   = 32'h0000_0130;
        pat_mem[14'h3000] = 12'h123;
        tile_mem[80]  = 32'h0000_010B;
        pat_mem[14'h0AB5] = 12'h456;
        tile_mem[1]   = 32'h0000_0101;
        pat_mem[148]  = 12'hF0F;
        tile_mem[2]   = 32'hFFFF_FEFF;
        tile_mem[3]   = 32'hFFFF_FF00;
        pat_mem[129]  = 12'h2B4;
        pat_mem[14'h16DC] = 12'h789;

        // Reset held 3 clocks with random inputs
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_tick    = 1'($urandom);
            video_on    = 1'($urandom);
            hsync_in    = 1'($urandom);
            vsync_in    = 1'($urandom);
            x           = 10'($urandom);
            y           = 10'($urandom);
            bg_x_offset = 4'($urandom);
            @(posedge clk);
        end
        #1;
        chk_all_zero("reset");
        reset       = 1'b0;
        pix_tick    = 1'b0;
        bg_x_offset = 4'd0;
        @(posedge clk);
        #1;

        // First pixel: latency and basic fetch
        n = tk;
        step(0, 0, 1'b1, 1'b1, 1'b1);
        flush3();
        chk("t2_ta_tick1", 32'(ta_log[n]), 32'h0);
        chk("t2_pa_tick3", 32'(pa_log[n+2]), 32'h3000);
        chk("t2_rgb_tick3", 32'(rgb_log[n+2]), 32'h0);
        chk("t2_rgb_tick4", 32'(rgb_log[n+3]), 32'(EXP_T2));
        chk("t2_opq_tick4", 32'(op_log[n+3]), 32'h1);
        chk("t2_vo_tick3", 32'(vo_log[n+2]), 32'h0);
        chk("t2_vo_tick4", 32'(vo_log[n+3]), 32'h1);
        chk("t2_hs_tick4", 32'(hs_log[n+3]), 32'h1);
        chk("t2_vs_tick4", 32'(vs_log[n+3]), 32'h1);
        chk("t2_hs_tick5", 32'(hs_log[n+4]), 32'h0);

        // Scroll 15 latched at x==0, column wrap at x=630
        bg_x_offset = 4'd15;
        step(0, 37, 1'b1, 1'b0, 1'b0);
        bg_x_offset = 4'd3;
        n = tk;
        step(630, 37, 1'b1, 1'b0, 1'b0);
        flush3();
        chk("t3_ta_wrap", 32'(ta_log[n]), 32'd80);
        chk("t3_pa", 32'(pa_log[n+2]), 32'h0AB5);
        chk("t3_rgb", 32'(rgb_log[n+3]), 32'h456);
        chk("t3_opq", 32'(op_log[n+3]), 32'h1);

        // x and y flip
        tile_mem[0] = 32'h0000_01D5;
        bg_x_offset = 4'd0;
        step(0, 2, 1'b1, 1'b0, 1'b0);
        n = tk;
        step(3, 2, 1'b1, 1'b0, 1'b0);
        flush3();
        chk("t4_pa_flip", 32'(pa_log[n+2]), 32'h16DC);
        chk("t4_rgb", 32'(rgb_log[n+3]), 32'h789);

        // Transparent texel, disabled tile, junk upper bits, video off
        step(0, 1, 1'b1, 1'b0, 1'b0);
        n = tk;
        step(20, 1, 1'b1, 1'b0, 1'b0);
        step(40, 1, 1'b1, 1'b0, 1'b0);
        step(49, 1, 1'b1, 1'b0, 1'b0);
        step(49, 1, 1'b0, 1'b0, 1'b0);
        flush3();
        chk("t5_transp_rgb", 32'(rgb_log[n+3]), 32'h6AF);
        chk("t5_transp_opq", 32'(op_log[n+3]), 32'h0);
        chk("t5_dis_ta", 32'(ta_log[n+1]), 32'd2);
        chk("t5_dis_rgb", 32'(rgb_log[n+4]), 32'h6AF);
        chk("t5_dis_opq", 32'(op_log[n+4]), 32'h0);
        chk("t5_junk_pa", 32'(pa_log[n+4]), 32'd129);
        chk("t5_junk_rgb", 32'(rgb_log[n+5]), 32'h2B4);
        chk("t5_junk_opq", 32'(op_log[n+5]), 32'h1);
        chk("t5_voff_rgb", 32'(rgb_log[n+6]), 32'h0);
        chk("t5_voff_opq", 32'(op_log[n+6]), 32'h0);

        // Row clamp below the active area
        n = tk;
        step(32, 490, 1'b0, 1'b0, 1'b0);
        chk("clamp_ta", 32'(ta_log[n]), 32'd1162);

        // Mid-line offset change waits for the next line
        bg_x_offset = 4'd0;
        step(0, 16, 1'b1, 1'b0, 1'b0);
        bg_x_offset = 4'd7;
        n = tk;
        step(105, 16, 1'b1, 1'b0, 1'b0);
        chk("t6_same_line", 32'(ta_log[n]), 32'd46);
        step(0, 17, 1'b1, 1'b0, 1'b0);
        n = tk;
        step(105, 17, 1'b1, 1'b0, 1'b0);
        chk("t6_next_line", 32'(ta_log[n]), 32'd47);

`ifdef BG_DEBUG_GRID_EN
        bg_x_offset = 4'd0;
        step(0, 5, 1'b1, 1'b0, 1'b0);
        n = tk;
        step(16, 5, 1'b1, 1'b0, 1'b0);
        flush3();
        chk("grid_rgb", 32'(rgb_log[n+3]), 32'hFFF);
        chk("grid_opq", 32'(op_log[n+3]), 32'h1);
`endif

        // Reset mid-frame flushes the pipeline
        bg_x_offset = 4'd0;
        step(49, 1, 1'b1, 1'b1, 1'b1);
        step(49, 1, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("midrst");
        reset = 1'b0;
        @(posedge clk);
        #1;
        n = tk;
        step(49, 1, 1'b1, 1'b0, 1'b0);
        flush3();
        chk("midrst_rgb_t3", 32'(rgb_log[n+2]), 32'h0);
        chk("midrst_rgb_t4", 32'(rgb_log[n+3]), 32'h2B4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
